// File: rtl/task_ctrl_block.sv
// Per-task scheduler control block: command decode, lifecycle FSM,
// hit budget, and priority aging feeding the priority sorter.
module task_ctrl_block #(
    parameter logic [3:0] TASK_ID    = 4'h8,
    parameter int         PRIO_W     = 8,
    parameter int         PRIO_INIT  = 0,
    parameter int         HIT_W      = 8,
    parameter int         HIT_INIT   = 128,
    parameter int         AGE_PERIOD = 10000,
    parameter int         CNT_W      = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [15:0]         in_op,
    output logic [4+PRIO_W-1:0] out_sorter,
    output logic                out_valid,
    output logic [2:0]          out_state,
    output logic [HIT_W-1:0]    out_hits,
    output logic                out_err
);

    typedef enum logic [2:0] {
        S_READY   = 3'b000,
        S_RUNNING = 3'b001,
        S_SUSP    = 3'b010,
        S_WAIT    = 3'b011,
        S_TERM    = 3'b100
    } state_t;

    localparam logic [PRIO_W-1:0] P_INIT   = PRIO_W'(PRIO_INIT);
    localparam logic [PRIO_W-1:0] P_MAX    = '1;
    localparam logic [HIT_W-1:0]  H_INIT   = HIT_W'(HIT_INIT);
    localparam logic [HIT_W-1:0]  H_MAX    = '1;
    localparam logic [CNT_W-1:0]  AGE_LAST = CNT_W'(AGE_PERIOD - 1);
    localparam logic              V_INIT   = (HIT_INIT != 0);

    state_t              r_state;
    logic [PRIO_W-1:0]   r_prio;
    logic [PRIO_W-1:0]   r_base;
    logic [HIT_W-1:0]    r_hits;
    logic [CNT_W-1:0]    r_age;
    logic                r_err;
    logic                r_valid;
    logic [4+PRIO_W-1:0] r_sorter;

    state_t              w_state_n;
    logic [PRIO_W-1:0]   w_prio_n;
    logic [PRIO_W-1:0]   w_base_n;
    logic [HIT_W-1:0]    w_hits_n;
    logic [CNT_W-1:0]    w_age_n;
    logic                w_err_n;
    logic                w_prio_wr;
    logic                w_valid_n;

    logic                w_addr;
    logic [3:0]          w_opc;
    logic [3:0]          w_arg;
    logic [HIT_W:0]      w_sum;
    logic                w_unused;

    assign w_addr   = (in_op[11:8] == TASK_ID);
    assign w_opc    = in_op[7:4];
    assign w_arg    = in_op[3:0];
    assign w_sum    = {1'b0, r_hits} + (HIT_W+1)'(w_arg);
    assign w_unused = ^in_op[15:12];

    always_comb begin
        w_state_n = r_state;
        w_prio_n  = r_prio;
        w_base_n  = r_base;
        w_hits_n  = r_hits;
        w_err_n   = 1'b0;
        w_prio_wr = 1'b0;
        if (w_addr) begin
            case (w_opc)
                4'h1: begin
                    if (r_state == S_SUSP) w_state_n = S_READY;
                    else                   w_err_n   = 1'b1;
                end
                4'h2: begin
                    if (r_state == S_READY || r_state == S_RUNNING ||
                        r_state == S_WAIT)
                        w_state_n = S_SUSP;
                    else
                        w_err_n = 1'b1;
                end
                4'h3: begin
                    if (r_state == S_READY || r_state == S_RUNNING)
                        w_state_n = S_WAIT;
                    else
                        w_err_n = 1'b1;
                end
                4'h4: begin
                    if (r_state != S_TERM) w_state_n = S_TERM;
                    else                   w_err_n   = 1'b1;
                end
                4'h5: begin
                    if (r_state != S_TERM) begin
                        w_base_n  = PRIO_W'(w_arg);
                        w_prio_n  = PRIO_W'(w_arg);
                        w_prio_wr = 1'b1;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
                4'h6: begin
                    if (r_state != S_TERM)
                        w_hits_n = w_sum[HIT_W] ? H_MAX : w_sum[HIT_W-1:0];
                    else
                        w_err_n = 1'b1;
                end
                4'h7: begin
                    if (r_state == S_READY && r_hits != '0) begin
                        w_state_n = S_RUNNING;
                        w_hits_n  = r_hits - 1'b1;
                        w_prio_n  = r_base;
                        w_prio_wr = 1'b1;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
                4'h8: begin
                    if (r_state == S_WAIT) w_state_n = S_READY;
                    else                   w_err_n   = 1'b1;
                end
                4'h9: begin
                    if (r_state == S_TERM) begin
                        w_state_n = S_READY;
                        w_base_n  = P_INIT;
                        w_prio_n  = P_INIT;
                        w_hits_n  = H_INIT;
                        w_prio_wr = 1'b1;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
                4'hF: begin
                    if (r_state == S_RUNNING)
                        w_state_n = (r_hits != '0) ? S_READY : S_TERM;
                    else
                        w_err_n = 1'b1;
                end
                default: ;
            endcase
        end

        // Aging only survives a cycle that stays in READY without a prio write.
        if (r_state != S_READY || w_state_n != S_READY || w_prio_wr) begin
            w_age_n = '0;
        end else if (r_age == AGE_LAST) begin
            w_age_n = '0;
            if (r_prio != P_MAX) w_prio_n = r_prio + 1'b1;
        end else begin
            w_age_n = r_age + 1'b1;
        end

        w_valid_n = (w_state_n == S_READY) && (w_hits_n != '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_READY;
            r_prio   <= P_INIT;
            r_base   <= P_INIT;
            r_hits   <= H_INIT;
            r_age    <= '0;
            r_err    <= 1'b0;
            r_valid  <= V_INIT;
            r_sorter <= V_INIT ? {TASK_ID, P_INIT} : '0;
        end else begin
            r_state  <= w_state_n;
            r_prio   <= w_prio_n;
            r_base   <= w_base_n;
            r_hits   <= w_hits_n;
            r_age    <= w_age_n;
            r_err    <= w_err_n;
            r_valid  <= w_valid_n;
            r_sorter <= w_valid_n ? {TASK_ID, w_prio_n} : '0;
        end
    end

    assign out_state  = r_state;
    assign out_hits   = r_hits;
    assign out_err    = r_err;
    assign out_valid  = r_valid;
    assign out_sorter = r_sorter;

endmodule

// File: doc/task_ctrl_block.md
Name: task_ctrl_block

Overview:
- Per-task control block for the hardware scheduler. Decodes 16-bit scheduler commands addressed to its task ID and runs a five-state task lifecycle.
- Tracks a remaining-execution-hit budget and ages the task's priority while it waits in READY.
- Presents a registered {id, priority} entry with a valid flag to the priority sorter.
- Parametrised successor of the fixed single-task control block. Adds RUNNING and event-wakeup states, priority aging with saturation, a restart command and an error flag.

Parameters:
- TASK_ID, 4'h8, 4-bit task ID matched against in_op[11:8].
- PRIO_W, 8, priority width.
- PRIO_INIT, 0, base priority after reset/RESTART.
- HIT_W, 8, execution-hit counter width.
- HIT_INIT, 128, hit budget after reset/RESTART.
- AGE_PERIOD, 10000, READY cycles per aging increment (>=2).
- CNT_W, 16, aging counter width (must hold AGE_PERIOD-1).

Ports:
- CLK, input, 1, clock.
- RST, input, 1, reset, asynchronous, active-high.
- in_op, input, 16, command: [15:12] ignored, [11:8] target ID, [7:4] opcode, [3:0] argument.
- out_sorter, output, 4+PRIO_W, {TASK_ID, prio} when out_valid, else all zero.
- out_valid, output, 1, task eligible for dispatch (READY and hits>0).
- out_state, output, 3, current state encoding.
- out_hits, output, HIT_W, remaining hits.
- out_err, output, 1, one-cycle pulse on an illegal addressed command.

Behaviour:
- Reset (async, RST=1):
  - state=READY, prio=PRIO_INIT, base=PRIO_INIT, hits=HIT_INIT, age_cnt=0.
  - out_err=0; out_valid and out_sorter follow from state (valid=1 if HIT_INIT>0).
  - Reset mid-operation aborts everything immediately.
- States: READY=000, RUNNING=001, SUSPENDED=010, WAIT=011, TERMINATED=100.
- Commands:
  - A command is addressed only when in_op[11:8]==TASK_ID; otherwise it is a no-op.
  - A command sampled at posedge N takes effect in the registers at that edge. Outputs are registered and reflect it from N onward, i.e. one-cycle latency.
- Opcodes (legal source -> action; an illegal source leaves all state unchanged and pulses out_err next cycle):
  - 0000 NOP: no action, no err.
  - 0001 READY: SUSPENDED -> READY.
  - 0010 SUSPEND: READY/RUNNING/WAIT -> SUSPENDED.
  - 0011 WAIT: READY/RUNNING -> WAIT.
  - 0100 KILL: any non-TERMINATED -> TERMINATED.
  - 0101 SET_PRIO: any non-TERMINATED; base=prio=zero-extended arg; age_cnt=0.
  - 0110 ADD_HIT: any non-TERMINATED; hits=min(hits+arg, 2^HIT_W-1).
  - 0111 EXECUTE: READY with hits>0 -> RUNNING; hits-=1; prio=base.
  - 1000 EVENT: WAIT -> READY.
  - 1001 RESTART: TERMINATED -> READY; prio=base=PRIO_INIT; hits=HIT_INIT.
  - 1111 FINISH: RUNNING -> READY if hits>0, else -> TERMINATED.
  - Other opcodes: no action, no err.
- Aging:
  - age_cnt increments only while state==READY; it is forced to 0 in every other state.
  - When age_cnt==AGE_PERIOD-1: age_cnt=0 and prio=min(prio+1, 2^PRIO_W-1), saturating with no wrap.
- Simultaneous events: an addressed command that writes prio (SET_PRIO, EXECUTE, RESTART) or leaves READY takes precedence over an aging tick in the same cycle. Any other command coexists with the tick.
- Output gating: out_valid = (state==READY) && (hits!=0). out_sorter is zero whenever out_valid=0.
- Boundaries:
  - hits==0 in READY: out_valid=0 and EXECUTE is an error. The task stays READY until ADD_HIT, KILL, etc.
  - ADD_HIT with arg=0: legal, no change.
  - prio at max: aging holds the value.

Test Plan:
- Reset/idle (TASK_ID=8, AGE_PERIOD=4): release RST -> state=000, hits=128, out_valid=1, out_sorter=0x800. After 4 READY cycles out_sorter=0x801; after 8 cycles 0x802.
- Execute/finish: in_op=0x0870 -> RUNNING, hits=127, out_valid=0, prio=base. Then 0x08F0 -> READY, out_sorter=0x800, age_cnt restarts.
- Exhaustion: SET hits via RESTART with HIT_INIT=1; EXECUTE then FINISH -> TERMINATED. EXECUTE in TERMINATED -> out_err=1 for exactly one cycle, state unchanged. 0x0890 -> READY, hits=1.
- Wait/event/suspend: from READY send 0x0830 -> WAIT. 0x0810 -> err pulse, still WAIT. 0x0880 -> READY. 0x0820 -> SUSPENDED. 0x0810 -> READY.
- Saturation and addressing: ADD_HIT 0x086F repeatedly from hits=250 -> sticks at 255. SET_PRIO 0x085F with PRIO_W=4 -> prio=15, aging holds 15. Command 0x0770 (ID 7) -> no change, no err.
- Precedence/reset: SET_PRIO 0x0853 in the same cycle age_cnt==AGE_PERIOD-1 -> prio=3, age_cnt=0. Assert RST while RUNNING -> immediately READY, hits=128, prio=0.
